// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the phase encoding used by the sync generator.
package vga_timing_pkg;

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;
   localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   typedef enum logic [1:0] {
      PH_VISIBLE = 2'd0,
      PH_FRONT   = 2'd1,
      PH_SYNC    = 2'd2,
      PH_BACK    = 2'd3
   } phase_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Counter inputs and registered timing outputs of vga_sync_gen; slave is the generator side.
interface vga_sync_gen_if #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned COORD_W = 10
);
   import vga_timing_pkg::*;

   logic [CNT_W-1:0]   HControl;
   logic [CNT_W-1:0]   VControl;
   logic               hSync;
   logic               vSync;
   logic               videoOn;
   logic [COORD_W-1:0] pixelX;
   logic [COORD_W-1:0] pixelY;
   phase_t             hPhase;
   phase_t             vPhase;
   logic               frameStart;
   logic [15:0]        frameCount;
   logic               timingErr;

   modport master (
      output HControl, VControl,
      input  hSync, vSync, videoOn, pixelX, pixelY, hPhase, vPhase,
             frameStart, frameCount, timingErr
   );

   modport slave (
      input  HControl, VControl,
      output hSync, vSync, videoOn, pixelX, pixelY, hPhase, vPhase,
             frameStart, frameCount, timingErr
   );

endinterface

// File: rtl/vga_phase_decode.sv
// Combinational decode of one counter axis into its timing phase; values past the total read BACK.
module vga_phase_decode import vga_timing_pkg::*; #(
   parameter int unsigned VISIBLE = 640,
   parameter int unsigned FRONT   = 16,
   parameter int unsigned SYNC    = 96,
   parameter int unsigned BACK    = 48,
   parameter int unsigned CNT_W   = 16
) (
   input  logic [CNT_W-1:0] cnt_i,
   output phase_t           phase_o,
   output logic             in_sync_o,
   output logic             in_visible_o,
   output logic             out_of_range_o
);

   localparam logic [CNT_W-1:0] FrontStart = CNT_W'(VISIBLE);
   localparam logic [CNT_W-1:0] SyncStart  = CNT_W'(VISIBLE + FRONT);
   localparam logic [CNT_W-1:0] BackStart  = CNT_W'(VISIBLE + FRONT + SYNC);
   localparam logic [CNT_W-1:0] Total      = CNT_W'(VISIBLE + FRONT + SYNC + BACK);

   always_comb begin
      phase_o = PH_BACK;
      if (cnt_i < FrontStart) begin
         phase_o = PH_VISIBLE;
      end else if (cnt_i < SyncStart) begin
         phase_o = PH_FRONT;
      end else if (cnt_i < BackStart) begin
         phase_o = PH_SYNC;
      end
   end

   assign in_sync_o      = (phase_o == PH_SYNC);
   assign in_visible_o   = (phase_o == PH_VISIBLE);
   assign out_of_range_o = (cnt_i >= Total);

endmodule

// File: rtl/vga_sync_gen.sv
// Registered VGA sync/blanking/coordinate generator with one cycle of latency.
// Optional sticky counter-sequence checker enabled by VGA_SYNC_TIMING_CHECK_EN.
module vga_sync_gen #(
   parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
   parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
   parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
   parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
   parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
   parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
   parameter bit          SYNC_POL  = 1'b0,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned COORD_W   = 10
) (
   input  logic         normalCLK,
   input  logic         resetN,
   vga_sync_gen_if.slave bus
);
   import vga_timing_pkg::*;

   phase_t h_phase, v_phase;
   logic   h_in_sync, h_in_vis, h_oor;
   logic   v_in_sync, v_in_vis, v_oor;

   vga_phase_decode #(
      .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CNT_W(CNT_W)
   ) u_h_decode (
      .cnt_i(bus.HControl), .phase_o(h_phase), .in_sync_o(h_in_sync),
      .in_visible_o(h_in_vis), .out_of_range_o(h_oor)
   );

   vga_phase_decode #(
      .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CNT_W(CNT_W)
   ) u_v_decode (
      .cnt_i(bus.VControl), .phase_o(v_phase), .in_sync_o(v_in_sync),
      .in_visible_o(v_in_vis), .out_of_range_o(v_oor)
   );

   logic               hsync_d, hsync_q, vsync_d, vsync_q;
   logic               video_on_d, video_on_q;
   logic [COORD_W-1:0] pixel_x_d, pixel_x_q, pixel_y_d, pixel_y_q;
   phase_t             h_phase_q, v_phase_q;
   logic               frame_start_d, frame_start_q;
   logic [15:0]        frame_count_d, frame_count_q;
   logic               blank;

   always_comb begin
      // Any out-of-range axis blanks the whole pixel, including both syncs.
      blank         = h_oor | v_oor;
      video_on_d    = h_in_vis & v_in_vis;
      hsync_d       = (h_in_sync & ~blank) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (v_in_sync & ~blank) ? SYNC_POL : ~SYNC_POL;
      pixel_x_d     = video_on_d ? bus.HControl[COORD_W-1:0] : '0;
      pixel_y_d     = video_on_d ? bus.VControl[COORD_W-1:0] : '0;
      frame_start_d = (bus.HControl == '0) && (bus.VControl == '0);
      frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
   end

   always_ff @(posedge normalCLK or negedge resetN) begin
      if (!resetN) begin
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         video_on_q    <= 1'b0;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         h_phase_q     <= PH_VISIBLE;
         v_phase_q     <= PH_VISIBLE;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         h_phase_q     <= h_phase;
         v_phase_q     <= v_phase;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign bus.hSync      = hsync_q;
   assign bus.vSync      = vsync_q;
   assign bus.videoOn    = video_on_q;
   assign bus.pixelX     = pixel_x_q;
   assign bus.pixelY     = pixel_y_q;
   assign bus.hPhase     = h_phase_q;
   assign bus.vPhase     = v_phase_q;
   assign bus.frameStart = frame_start_q;
   assign bus.frameCount = frame_count_q;

`ifdef VGA_SYNC_TIMING_CHECK_EN
   localparam logic [CNT_W-1:0] HLast = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [CNT_W-1:0] VLast = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

   logic [CNT_W-1:0] prev_h_q, prev_v_q;
   logic             hist_valid_q;
   logic             timing_err_d, timing_err_q;
   logic             h_wrap, h_ok, v_ok;

   always_comb begin
      h_wrap = (prev_h_q == HLast);
      h_ok   = (bus.HControl == prev_h_q + 1'b1) || (h_wrap && bus.HControl == '0);
      v_ok   = h_wrap ? ((bus.VControl == prev_v_q + 1'b1) ||
                         (prev_v_q == VLast && bus.VControl == '0))
                      : (bus.VControl == prev_v_q);
      timing_err_d = timing_err_q | (hist_valid_q & (~h_ok | ~v_ok | blank));
   end

   always_ff @(posedge normalCLK or negedge resetN) begin
      if (!resetN) begin
         prev_h_q     <= '0;
         prev_v_q     <= '0;
         hist_valid_q <= 1'b0;
         timing_err_q <= 1'b0;
      end else begin
         prev_h_q     <= bus.HControl;
         prev_v_q     <= bus.VControl;
         hist_valid_q <= 1'b1;
         timing_err_q <= timing_err_d;
      end
   end

   assign bus.timingErr = timing_err_q;
`else
   assign bus.timingErr = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed self-checking bench for vga_sync_gen: reset, line/frame sweeps, range and mid-frame reset.
module tb_vga_sync_gen;
   import vga_timing_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   vga_sync_gen_if #(.CNT_W(16), .COORD_W(10)) bus ();

   vga_sync_gen dut (
      .normalCLK(clk),
      .resetN   (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present (h,v) and return just after the edge that registers it.
   task automatic drive(input int h, input int v);
      bus.HControl = 16'(h);
      bus.VControl = 16'(v);
      @(posedge clk);
      #1;
   endtask

   function automatic int h_phase_of(input int h);
      if (h < 640) return 0;
      if (h < 656) return 1;
      if (h < 752) return 2;
      return 3;
   endfunction

   function automatic int v_phase_of(input int v);
      if (v < 480) return 0;
      if (v < 490) return 1;
      if (v < 492) return 2;
      return 3;
   endfunction

   initial begin
      int prev_x;
      int low_cnt;
      int trans;
      int last_vp;
      int pulses;
      int last_pulse;
      int cyc;
      int exp_err;

`ifdef VGA_SYNC_TIMING_CHECK_EN
      exp_err = 1;
`else
      exp_err = 0;
`endif

      // Reset held with counters mid-line.
      bus.HControl = 16'd700;
      bus.VControl = 16'd300;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hsync", bus.hSync, 1);
      check("rst_vsync", bus.vSync, 1);
      check("rst_video_on", bus.videoOn, 0);
      check("rst_pixel_x", bus.pixelX, 0);
      check("rst_pixel_y", bus.pixelY, 0);
      check("rst_h_phase", bus.hPhase, 0);
      check("rst_v_phase", bus.vPhase, 0);
      check("rst_frame_start", bus.frameStart, 0);
      check("rst_frame_count", bus.frameCount, 0);
      check("rst_timing_err", bus.timingErr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // One visible line at V=10, with a lag check before each edge.
      prev_x = 0;
      for (int h = 0; h < 800; h++) begin
         bus.HControl = 16'(h);
         bus.VControl = 16'd10;
         #2;
         if (h > 0) check("lag_pixel_x", bus.pixelX, prev_x);
         @(posedge clk);
         #1;
         check("h_video_on", bus.videoOn, (h < 640) ? 1 : 0);
         check("h_pixel_x", bus.pixelX, (h < 640) ? h : 0);
         check("h_pixel_y", bus.pixelY, (h < 640) ? 10 : 0);
         check("h_hsync", bus.hSync, (h >= 656 && h <= 751) ? 0 : 1);
         check("h_phase", bus.hPhase, h_phase_of(h));
         check("h_vsync", bus.vSync, 1);
         check("h_frame_start", bus.frameStart, 0);
         prev_x = (h < 640) ? h : 0;
      end

      // Lines 478..493 cover the end of visible area, front porch, sync and start of back porch.
      low_cnt = 0;
      trans   = 0;
      last_vp = 0;
      for (int v = 478; v < 494; v++) begin
         for (int h = 0; h < 800; h++) begin
            drive(h, v);
            if (!bus.vSync) low_cnt++;
            check("v_vsync", bus.vSync, (v == 490 || v == 491) ? 0 : 1);
            check("v_phase", bus.vPhase, v_phase_of(v));
            check("v_video_on", bus.videoOn, (v < 480 && h < 640) ? 1 : 0);
            if (int'(bus.vPhase) != last_vp) begin
               trans++;
               check("v_phase_step", bus.vPhase, last_vp + 1);
               last_vp = int'(bus.vPhase);
            end
         end
      end
      check("v_sync_low_clocks", low_cnt, 1600);
      check("v_phase_transitions", trans, 3);

      // Three frame boundaries, each reached from the last pixel of the previous frame.
      pulses     = 0;
      last_pulse = -1;
      cyc        = 0;
      for (int f = 0; f < 3; f++) begin
         for (int s = 0; s < 11; s++) begin
            if (s == 0) drive(799, 524);
            else drive(s - 1, 0);
            cyc++;
            if (bus.frameStart) begin
               pulses++;
               if (last_pulse >= 0) check("frame_interval", cyc - last_pulse, 11);
               last_pulse = cyc;
            end
            check("frame_start", bus.frameStart, (s == 1) ? 1 : 0);
         end
         check("frame_count", bus.frameCount, f + 1);
      end
      check("frame_pulses", pulses, 3);

      // Out-of-range inputs.
      drive(900, 100);
      check("oor_h_video_on", bus.videoOn, 0);
      check("oor_h_hsync", bus.hSync, 1);
      check("oor_h_vsync", bus.vSync, 1);
      check("oor_h_h_phase", bus.hPhase, 3);
      check("oor_h_v_phase", bus.vPhase, 0);
      check("oor_h_pixel_x", bus.pixelX, 0);
      check("oor_timing_err", bus.timingErr, exp_err);
      drive(0, 101);
      drive(1, 101);
      check("oor_timing_err_sticky", bus.timingErr, exp_err);
      drive(100, 600);
      check("oor_v_video_on", bus.videoOn, 0);
      check("oor_v_v_phase", bus.vPhase, 3);
      check("oor_v_h_phase", bus.hPhase, 0);
      check("oor_v_pixel_y", bus.pixelY, 0);
      drive(700, 491);
      check("both_sync_hsync", bus.hSync, 0);
      check("both_sync_vsync", bus.vSync, 0);
      drive(700, 600);
      check("oor_v_hsync_blank", bus.hSync, 1);
      check("oor_v_vsync_blank", bus.vSync, 1);

      // Asynchronous reset in the middle of the visible area.
      drive(320, 240);
      check("mid_video_on", bus.videoOn, 1);
      check("mid_pixel_x", bus.pixelX, 320);
      check("mid_pixel_y", bus.pixelY, 240);
      rst_n = 1'b0;
      #1;
      check("mid_rst_video_on", bus.videoOn, 0);
      check("mid_rst_pixel_x", bus.pixelX, 0);
      check("mid_rst_pixel_y", bus.pixelY, 0);
      check("mid_rst_frame_count", bus.frameCount, 0);
      check("mid_rst_hsync", bus.hSync, 1);
      check("mid_rst_timing_err", bus.timingErr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(799, 524);
      check("post_rst_frame_count_pre", bus.frameCount, 0);
      drive(0, 0);
      check("post_rst_frame_start", bus.frameStart, 1);
      check("post_rst_frame_count", bus.frameCount, 1);
      check("post_rst_timing_err", bus.timingErr, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
